mem_port_arbiter: RTL

- Shares the single external memory port between the instruction-cache refill, data-cache refill and MMU page-table-walker requesters.
- Grants one requester at a time and sequences its multi-beat burst, generating beat addresses.
- Handles requester kills, e.g. an instruction refill abandoned on a redirect, by draining the in-flight beat safely.
- Sits between the cache/MMU miss logic and the memory bus.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_picker.sv | 36 +++
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
// Requester slot k of every packed bus belongs to requester index k.
package mem_arb_pkg;

    localparam int MEM_ARB_N_REQ  = 3;
    localparam int MEM_ARB_ADDR_W = 32;
    localparam int MEM_ARB_DATA_W = 32;
    localparam int MEM_ARB_LEN_W  = 4;

    localparam int MEM_ARB_PTW    = 0;
    localparam int MEM_ARB_DCACHE = 1;
    localparam int MEM_ARB_ICACHE = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } type_mem_arb_state_e;

endpackage

// File: rtl/arb_picker.sv
// Combinational one-hot winner search starting at ptr_i and wrapping modulo N_REQ.
// Fixed priority is the special case of ptr_i tied to zero.
module arb_picker #(
    parameter int N_REQ = 3,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    localparam logic [PTR_W:0] N_L = (PTR_W+1)'(N_REQ);

    // NOTE: every output gets a default before the search loop so no latch is inferred.
    always_comb begin
        logic [PTR_W:0] w_cand;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (w_cand >= N_L) begin
                w_cand = w_cand - N_L;
            end
            if (!valid_o && req_i[w_cand[PTR_W-1:0]]) begin
                valid_o                     = 1'b1;
                grant_o[w_cand[PTR_W-1:0]]  = 1'b1;
                idx_o                       = w_cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between PTW, dcache and icache burst requesters.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ  = MEM_ARB_N_REQ,
    parameter int ADDR_W = MEM_ARB_ADDR_W,
    parameter int DATA_W = MEM_ARB_DATA_W,
    parameter int LEN_W  = MEM_ARB_LEN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         kill_i,
    input  logic [N_REQ-1:0]         we_i,
    input  logic [N_REQ*ADDR_W-1:0]  addr_i,
    input  logic [N_REQ*LEN_W-1:0]   len_i,
    input  logic [N_REQ*DATA_W-1:0]  wdata_i,
    output logic [N_REQ-1:0]         ack_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    input  logic                     mem_ack_i,
    input  logic [DATA_W-1:0]        mem_rdata_i
);

    localparam int                PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

    type_mem_arb_state_e r_state, w_state_nxt;
    logic [N_REQ-1:0]    r_grant, w_grant_nxt;
    logic [PTR_W-1:0]    r_owner, w_owner_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [LEN_W-1:0]    r_len, w_len_nxt;
    logic [LEN_W-1:0]    r_cnt, w_cnt_nxt;
    logic                r_killed, w_killed_nxt;

    logic                w_pick_valid;
    logic [N_REQ-1:0]    w_pick_grant;
    logic [PTR_W-1:0]    w_pick_idx;
    logic [PTR_W-1:0]    w_ptr;
    logic                w_owner_kill;
    logic                w_done;

    arb_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req_i   (req_i),
        .ptr_i   (w_ptr),
        .grant_o (w_pick_grant),
        .idx_o   (w_pick_idx),
        .valid_o (w_pick_valid)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] r_ptr;

    // Pointer moves past the owner whenever a transaction ends, killed or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_done) begin
            r_ptr <= (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    assign w_owner_kill = |(kill_i & r_grant);

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_owner_nxt    = r_owner;
        w_busy_nxt     = r_busy;
        w_mem_req_nxt  = r_mem_req;
        w_mem_we_nxt   = r_mem_we;
        w_mem_addr_nxt = r_mem_addr;
        w_len_nxt      = r_len;
        w_cnt_nxt      = r_cnt;
        w_killed_nxt   = r_killed;
        w_done         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt    = BUSY;
                    w_grant_nxt    = w_pick_grant;
                    w_owner_nxt    = w_pick_idx;
                    w_busy_nxt     = 1'b1;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = we_i[w_pick_idx];
                    w_mem_addr_nxt = addr_i[w_pick_idx*ADDR_W +: ADDR_W];
                    w_len_nxt      = len_i[w_pick_idx*LEN_W +: LEN_W];
                    w_cnt_nxt      = '0;
                    w_killed_nxt   = 1'b0;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    // A kill landing with an ack still delivers that beat, then ends.
                    if (w_owner_kill || (r_cnt == r_len)) begin
                        w_done = 1'b1;
                    end else begin
                        w_cnt_nxt      = r_cnt + 1'b1;
                        w_mem_addr_nxt = r_mem_addr + BEAT_BYTES;
                    end
                end else if (w_owner_kill) begin
                    w_state_nxt  = DRAIN;
                    w_killed_nxt = 1'b1;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    w_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_done) begin
            w_state_nxt   = IDLE;
            w_grant_nxt   = '0;
            w_busy_nxt    = 1'b0;
            w_mem_req_nxt = 1'b0;
            w_mem_we_nxt  = 1'b0;
            w_killed_nxt  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_busy     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_killed   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_owner    <= w_owner_nxt;
            r_busy     <= w_busy_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_len      <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            r_killed   <= w_killed_nxt;
        end
    end

    assign ack_o       = r_grant & {N_REQ{mem_ack_i & ~r_killed}};
    assign rdata_o     = mem_rdata_i;
    assign grant_o     = r_grant;
    assign busy_o      = r_busy;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_busy ? wdata_i[r_owner*DATA_W +: DATA_W] : '0;

endmodule
